// File: rtl/core_bram_pkg.sv
// Shared types and helpers for the BRAM port arbiter slice.
// Address width is derived from depth so addr == Depth is representable.
package core_bram_pkg;

   localparam int DefDepth     = 1024;
   localparam int DefDataWidth = 16;

   function automatic int addr_width(input int depth);
      return $clog2(depth + 1);
   endfunction

   // Default-sized command; users with other sizes redeclare it locally
   // with addr_width(Depth) so the layout stays identical.
   typedef struct packed {
      logic                                write;
      logic [addr_width(DefDepth)-1:0]     addr;
      logic [DefDataWidth-1:0]             data;
   } bram_cmd_t;

endpackage

// File: rtl/core_rr_arbiter.sv
// Round-robin arbiter: one-hot grant plus index, pointer advances past
// each winner. Grant is forced low while reset is asserted.
module core_rr_arbiter #(
   parameter  int NumReq = 2,
   localparam int TW     = (NumReq > 1) ? $clog2(NumReq) : 1
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [NumReq-1:0] req_i,
   output logic [NumReq-1:0] grant_o,
   output logic [TW-1:0]     idx_o
);

   logic [TW-1:0] ptr_q, ptr_d;
   logic          found;

   // Search from the pointer, wrapping modulo NumReq; first valid wins
   always_comb begin
      int j;
      grant_o = '0;
      idx_o   = '0;
      found   = 1'b0;
      j       = 0;
      for (int k = 0; k < NumReq; k++) begin
         j = int'(ptr_q) + k;
         if (j >= NumReq) j = j - NumReq;
         if (!found && req_i[j] && !rst_i) begin
            found = 1'b1;
            idx_o = TW'(j);
         end
      end
      if (found) grant_o[idx_o] = 1'b1;
   end

   // Next pointer is one past the winner; held when nothing is granted
   always_comb begin
      ptr_d = ptr_q;
      if (found) begin
         if (int'(idx_o) == NumReq - 1) ptr_d = '0;
         else                           ptr_d = idx_o + TW'(1);
      end
   end

   // Pointer register
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) ptr_q <= '0;
      else       ptr_q <= ptr_d;
   end

endmodule

// File: rtl/core_bram_port_arbiter.sv
// Shares one single-port BRAM between NumReq valid/ready requesters.
// Optional macro: CORE_BRAM_PORT_ARBITER_BOUNDS_CHECK_EN (address check).
module core_bram_port_arbiter
   import core_bram_pkg::*;
#(
   parameter  int NumReq    = 2,
   parameter  int DataWidth = DefDataWidth,
   parameter  int Depth     = DefDepth,
   localparam int AW        = addr_width(Depth),
   localparam int TW        = (NumReq > 1) ? $clog2(NumReq) : 1
) (
   input  logic                        clk_i,
   input  logic                        rst_i,
   input  logic [NumReq-1:0]           req_valid_i,
   input  logic [NumReq-1:0]           req_write_i,
   input  logic [NumReq*AW-1:0]        req_addr_i,
   input  logic [NumReq*DataWidth-1:0] req_data_i,
   output logic [NumReq-1:0]           req_ready_o,
   output logic [NumReq-1:0]           rsp_valid_o,
   output logic [DataWidth-1:0]        rsp_data_o,
   output logic                        bram_write_en_o,
   output logic [AW-1:0]               bram_addr_o,
   output logic [DataWidth-1:0]        bram_data_o,
   input  logic [DataWidth-1:0]        bram_data_i,
   output logic                        error_o
);

   typedef struct packed {
      logic                 write;
      logic [AW-1:0]        addr;
      logic [DataWidth-1:0] data;
   } cmd_t;

   logic [NumReq-1:0] grant;
   logic [TW-1:0]     idx;
   logic              accept;
   logic              oob;
   cmd_t              cmd;

   logic                 we_q, we_d;
   logic [AW-1:0]        addr_q, addr_d;
   logic [DataWidth-1:0] data_q, data_d;
   logic                 c_valid_q, c_valid_d;
   logic [TW-1:0]        c_tag_q, c_tag_d;
   logic                 c_oob_q, c_oob_d;
   logic                 r_valid_q, r_valid_d;
   logic [TW-1:0]        r_tag_q, r_tag_d;
   logic                 r_oob_q, r_oob_d;

   core_rr_arbiter #(
      .NumReq (NumReq)
   ) u_arb (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .req_i   (req_valid_i),
      .grant_o (grant),
      .idx_o   (idx)
   );

   assign req_ready_o = grant;
   assign accept      = |grant;

   // Select the granted requester's command fields
   always_comb begin
      cmd.write = req_write_i[idx];
      cmd.addr  = req_addr_i[int'(idx)*AW +: AW];
      cmd.data  = req_data_i[int'(idx)*DataWidth +: DataWidth];
   end

`ifdef CORE_BRAM_PORT_ARBITER_BOUNDS_CHECK_EN
   logic error_q, error_d;

   assign oob = cmd.addr >= AW'(Depth);

   // Error is sticky until reset
   always_comb begin
      error_d = error_q | (accept & oob);
   end

   // Error flag register
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) error_q <= 1'b0;
      else       error_q <= error_d;
   end

   assign error_o = error_q;
`else
   assign oob     = 1'b0;
   assign error_o = 1'b0;
`endif

   // Stage C issues the command to the BRAM; stage R tags the read data
   always_comb begin
      we_d      = accept & cmd.write & ~oob;
      addr_d    = accept ? cmd.addr : addr_q;
      data_d    = accept ? cmd.data : data_q;
      c_valid_d = accept;
      c_tag_d   = accept ? idx : c_tag_q;
      c_oob_d   = accept & oob;
      r_valid_d = c_valid_q;
      r_tag_d   = c_tag_q;
      r_oob_d   = c_oob_q;
   end

   // Pipeline registers; in-flight work is dropped on reset
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         we_q      <= 1'b0;
         addr_q    <= '0;
         data_q    <= '0;
         c_valid_q <= 1'b0;
         c_tag_q   <= '0;
         c_oob_q   <= 1'b0;
         r_valid_q <= 1'b0;
         r_tag_q   <= '0;
         r_oob_q   <= 1'b0;
      end else begin
         we_q      <= we_d;
         addr_q    <= addr_d;
         data_q    <= data_d;
         c_valid_q <= c_valid_d;
         c_tag_q   <= c_tag_d;
         c_oob_q   <= c_oob_d;
         r_valid_q <= r_valid_d;
         r_tag_q   <= r_tag_d;
         r_oob_q   <= r_oob_d;
      end
   end

   assign bram_write_en_o = we_q;
   assign bram_addr_o     = addr_q;
   assign bram_data_o     = data_q;

   // Response strobe is the one-hot of the tag in stage R
   always_comb begin
      rsp_valid_o = '0;
      for (int i = 0; i < NumReq; i++) begin
         rsp_valid_o[i] = r_valid_q && (r_tag_q == TW'(i));
      end
   end

   // Read data passes straight through; out-of-range slots read as zero
   always_comb begin
      rsp_data_o = bram_data_i;
      if (rst_i || r_oob_q) rsp_data_o = '0;
   end

endmodule

// File: tb/tb_core_bram_port_arbiter.sv
// Scoreboard bench for core_bram_port_arbiter with a behavioural BRAM.
// Build with CORE_BRAM_PORT_ARBITER_BOUNDS_CHECK_EN to cover the check.
module tb_core_bram_port_arbiter;

   localparam int AW = 11;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [1:0]  v = '0;
   logic [1:0]  w = '0;
   logic [21:0] addr = '0;
   logic [31:0] wdata = '0;
   logic [1:0]  ready;
   logic [1:0]  rsp_valid;
   logic [15:0] rsp_data;
   logic        bram_we;
   logic [10:0] bram_addr;
   logic [15:0] bram_wd;
   logic [15:0] bram_q;
   logic        error;
   logic        mem_clr = 1'b1;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   typedef struct {
      int          cyc;
      int          tag;
      logic [15:0] data;
   } exp_t;

   exp_t sbq[$];

   core_bram_port_arbiter #(
      .NumReq    (2),
      .DataWidth (16),
      .Depth     (1024)
   ) dut (
      .clk_i           (clk),
      .rst_i           (rst),
      .req_valid_i     (v),
      .req_write_i     (w),
      .req_addr_i      (addr),
      .req_data_i      (wdata),
      .req_ready_o     (ready),
      .rsp_valid_o     (rsp_valid),
      .rsp_data_o      (rsp_data),
      .bram_write_en_o (bram_we),
      .bram_addr_o     (bram_addr),
      .bram_data_o     (bram_wd),
      .bram_data_i     (bram_q),
      .error_o         (error)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Single-port BRAM, registered read, read-before-write
   logic [15:0] mem [0:2047];
   always @(posedge clk) begin
      if (mem_clr) begin
         for (int i = 0; i < 2048; i++) mem[i] = 16'h0;
         bram_q <= 16'h0;
      end else begin
         bram_q <= mem[bram_addr];
         if (bram_we) mem[bram_addr] = bram_wd;
      end
   end

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h (cycle %0d)",
                  nm, act, exp, cyc);
      end
   endtask

   // Monitor: pop and compare on every response strobe
   always @(negedge clk) begin
      if (!rst) begin
         if (sbq.size() > 0 && sbq[0].cyc < cyc) begin
            total++;
            bad++;
            $display("FAIL missing_rsp: got none expected tag %0d at %0d",
                     sbq[0].tag, sbq[0].cyc);
            void'(sbq.pop_front());
         end
         if (rsp_valid != 2'b00) begin
            if (sbq.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_rsp: got %b expected none (cycle %0d)",
                        rsp_valid, cyc);
            end else begin
               exp_t e;
               logic [1:0] oh;
               e  = sbq.pop_front();
               oh = 2'b01 << e.tag;
               chk("rsp_cycle", cyc, e.cyc);
               chk("rsp_valid", {30'b0, rsp_valid}, {30'b0, oh});
               chk("rsp_data", {16'b0, rsp_data}, {16'b0, e.data});
            end
         end
      end
   end

   // One cycle of stimulus; checks grant and queues hand-computed responses
   task automatic step(input logic [1:0] vv, input logic [1:0] ww,
                       input logic [10:0] a0, input logic [10:0] a1,
                       input logic [15:0] d0, input logic [15:0] d1,
                       input logic [1:0] er,
                       input logic [15:0] x0, input logic [15:0] x1);
      exp_t e;
      @(posedge clk);
      #1;
      v     = vv;
      w     = ww;
      addr  = {a1, a0};
      wdata = {d1, d0};
      @(negedge clk);
      chk("grant", {30'b0, ready}, {30'b0, er});
      for (int i = 0; i < 2; i++) begin
         if (er[i]) begin
            e.cyc  = cyc + 2;
            e.tag  = i;
            e.data = (i == 0) ? x0 : x1;
            sbq.push_back(e);
         end
      end
   endtask

   task automatic idle();
      step(2'b00, 2'b00, 11'd0, 11'd0, 16'h0, 16'h0, 2'b00, 16'h0, 16'h0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      v = 2'b11;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_ready", {30'b0, ready}, 32'h0);
      chk("rst_rsp_valid", {30'b0, rsp_valid}, 32'h0);
      chk("rst_we", {31'b0, bram_we}, 32'h0);
      chk("rst_addr", {21'b0, bram_addr}, 32'h0);
      chk("rst_wdata", {16'b0, bram_wd}, 32'h0);
      chk("rst_rsp_data", {16'b0, rsp_data}, 32'h0);
      chk("rst_error", {31'b0, error}, 32'h0);
      @(posedge clk);
      #1;
      rst     = 1'b0;
      mem_clr = 1'b0;
      v       = 2'b00;

      // preload mem[5] via a write, then read it back
      step(2'b01, 2'b01, 11'd5, 11'd0, 16'hA5A5, 16'h0, 2'b01, 16'h0, 16'h0);
      step(2'b01, 2'b00, 11'd5, 11'd0, 16'h0, 16'h0, 2'b01, 16'hA5A5, 16'h0);

      // contention, pointer at 1
      for (int k = 0; k < 4; k++) begin
         step(2'b11, 2'b00, 11'd5, 11'd7, 16'h0, 16'h0,
              (k % 2 == 0) ? 2'b10 : 2'b01, 16'hA5A5, 16'h0);
      end

      // write then read same address
      step(2'b10, 2'b10, 11'd0, 11'd7, 16'h0, 16'h1234, 2'b10, 16'h0, 16'h0);
      step(2'b01, 2'b00, 11'd7, 11'd0, 16'h0, 16'h0, 2'b01, 16'h1234, 16'h0);

      // idle gaps; pointer stays at 1
      repeat (3) idle();
      chk("idle_we", {31'b0, bram_we}, 32'h0);
      chk("idle_rsp_valid", {30'b0, rsp_valid}, 32'h0);
      step(2'b11, 2'b00, 11'd5, 11'd7, 16'h0, 16'h0, 2'b10, 16'h0, 16'h1234);

      // reset one cycle after accepting a write
      step(2'b01, 2'b01, 11'd5, 11'd0, 16'h7777, 16'h0, 2'b01, 16'hA5A5, 16'h0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      v   = 2'b11;
      w   = 2'b00;
      sbq.delete();
      #1;
      chk("midrst_ready", {30'b0, ready}, 32'h0);
      chk("midrst_we", {31'b0, bram_we}, 32'h0);
      chk("midrst_rsp_valid", {30'b0, rsp_valid}, 32'h0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      v   = 2'b00;
      repeat (4) idle();
      // pointer back at 0; aborted write must not have landed
      step(2'b11, 2'b00, 11'd5, 11'd7, 16'h0, 16'h0, 2'b01, 16'hA5A5, 16'h0);

      // address equal to Depth
      step(2'b01, 2'b01, 11'd1024, 11'd0, 16'hFFFF, 16'h0, 2'b01, 16'h0, 16'h0);
      chk("oob_err_n", {31'b0, error}, 32'h0);
      idle();
`ifdef CORE_BRAM_PORT_ARBITER_BOUNDS_CHECK_EN
      chk("oob_we", {31'b0, bram_we}, 32'h0);
      chk("oob_err_n1", {31'b0, error}, 32'h1);
      step(2'b01, 2'b00, 11'd1024, 11'd0, 16'h0, 16'h0, 2'b01, 16'h0, 16'h0);
      repeat (3) idle();
      chk("oob_err_sticky", {31'b0, error}, 32'h1);
`else
      chk("oob_we", {31'b0, bram_we}, 32'h1);
      chk("oob_err_n1", {31'b0, error}, 32'h0);
      step(2'b01, 2'b00, 11'd1024, 11'd0, 16'h0, 16'h0, 2'b01, 16'hFFFF, 16'h0);
      repeat (3) idle();
      chk("oob_err_sticky", {31'b0, error}, 32'h0);
`endif

      chk("sb_empty", sbq.size(), 32'h0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/core_bram_port_arbiter.md
Name: core_bram_port_arbiter

Overview:
Round-robin arbiter that shares one single-port BRAM (1-cycle registered read, read-before-write) between NumReq requesters.
- Each requester uses a valid/ready request channel. It receives a tagged response with read data for every accepted request.
- Placed between the layer engines (weight loader, activation writer, debug readback) and one BRAM instance.
- Sustains one access per cycle.

Parameters:
NumReq, 2, number of requesters (>=1)
DataWidth, 16, BRAM word width
Depth, 1024, BRAM depth in words; address width AW = $clog2(Depth+1)

Ports:
clk_i  in  1  clock, all state on rising edge
rst_i  in  1  asynchronous, active-high reset
req_valid_i  in  NumReq  request valid per requester
req_write_i  in  NumReq  1 = write, 0 = read
req_addr_i  in  NumReq*AW  packed addresses, requester i at [i*AW +: AW]
req_data_i  in  NumReq*DataWidth  packed write data
req_ready_o  out  NumReq  one-hot grant (combinational from valids and pointer)
rsp_valid_o  out  NumReq  one-hot response strobe
rsp_data_o  out  DataWidth  word read at the granted address (old contents for writes)
bram_write_en_o  out  1  to BRAM write_en_i
bram_addr_o  out  AW  to BRAM addr_i
bram_data_o  out  DataWidth  to BRAM data_i
bram_data_i  in  DataWidth  from BRAM data_o
error_o  out  1  sticky out-of-bounds flag (see Optional Feature)

Behaviour:
- Reset (async assert, sync deassert by the system):
  - req_ready_o, rsp_valid_o, bram_write_en_o, bram_addr_o, bram_data_o, rsp_data_o, error_o = 0.
  - RR pointer = 0.
  - Pipeline valid/tag registers cleared; in-flight requests discarded with no response.
- Arbitration (comb):
  - Grant the first i with req_valid_i[i]=1, searching from pointer, pointer+1, … modulo NumReq.
  - req_ready_o[i] = 1 only for the granted i. No valids -> all 0.
  - Accept = valid & ready in the same cycle.
  - Requester must hold valid/write/addr/data stable until accepted.
- Pointer: on accept of i, pointer <= (i+1) mod NumReq. No accept -> pointer unchanged.
- Stage C (edge after accept):
  - bram_addr_o/bram_data_o <= granted fields.
  - bram_write_en_o <= granted write bit.
  - c_valid <= 1; c_tag <= i.
  - With no accept: bram_write_en_o <= 0, c_valid <= 0; addr/data hold.
- Stage R (next edge):
  - BRAM presents its data on bram_data_i one cycle after stage C.
  - r_valid <= c_valid, r_tag <= c_tag.
  - rsp_valid_o = r_valid ? onehot(r_tag) : 0; rsp_data_o = bram_data_i (comb pass-through, 0-masking not required).
- Latency: accept in cycle N -> rsp_valid_o in cycle N+2. Throughput 1/cycle. Responses are in accept order and cannot be stalled.
- Same-address write then read in back-to-back cycles: the read returns the new data (BRAM ordering). The write's own response carries the old data.
- NumReq=1: pointer is constant 0; ready = valid.

Optional Feature:
Macro CORE_BRAM_PORT_ARBITER_BOUNDS_CHECK_EN.
- Defined:
  - An accepted request with addr >= Depth is still accepted and still gets a response, with rsp_data_o = 0.
  - Writes are suppressed (bram_write_en_o = 0 for that slot).
  - error_o sets the cycle after acceptance and stays 1 until reset.
- Undefined: no check; error_o tied 0; out-of-range addresses pass to the BRAM unchanged.

Decomposition:
- Package core_bram_pkg holds:
  - function addr_width(Depth) = $clog2(Depth+1)
  - typedef of the command struct {write, addr, data}, parameterised via the function at use site
  - localparam default depth/width
- One sub-module: core_rr_arbiter (NumReq valids + pointer in, one-hot grant + index out, pointer update). It is reusable for other shared resources.

Test Plan:
- Single read: preload BRAM[5]=16'hA5A5; req0 read addr 5 at cycle 0 -> ready0=1 cycle 0; rsp_valid_o=2'b01, rsp_data_o=16'hA5A5 at cycle 2.
- Contention: req0 and req1 both valid for 4 cycles (NumReq=2, pointer 0) -> grants 0,1,0,1. Responses alternate 01,10,01,10 in cycles 2..5.
- Write then read: req1 writes 16'h1234 to addr 7 at cycle 0 (old value 16'h0000), req0 reads addr 7 at cycle 1. Expected: rsp1 data 16'h0000 at cycle 2, then rsp0 data 16'h1234 at cycle 3.
- Idle gaps: no valids for 3 cycles -> bram_write_en_o=0, rsp_valid_o=0, pointer unchanged. The next single request is granted immediately.
- Reset mid-flight: assert rst_i one cycle after accept -> rsp_valid_o, bram_write_en_o, req_ready_o go 0 immediately, and no response appears after deassert.
- Bounds (macro on, Depth=1024): write to addr 1024 -> bram_write_en_o stays 0, rsp_data_o=0 at N+2, error_o=1 from N+1 until reset.
